// File: rtl/i2c_fifo.sv
// i2c_fifo: single-clock synchronous FIFO with first-word fall-through output.
//
// Parameters:
//   DWIDTH    data word width in bits
//   AWIDTH    address width; depth is 2**AWIDTH words
// Ports:
//   PCLK      clock, all state changes on its rising edge
//   PRESETn   asynchronous active-low reset
//   WR_ENA    write request
//   RD_ENA    read request
//   DATA_IN   word stored when a write is accepted
//   DATA_OUT  head-of-queue word, zero while empty
//   F_FULL    registered full flag
//   F_EMPTY   registered empty flag
//   COUNT     number of stored words, 0 to depth
//   OVERFLOW  registered pulse, a write was rejected on the previous edge
//   UNDERFLOW registered pulse, a read was rejected on the previous edge
module i2c_fifo #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              WR_ENA,
    input  logic              RD_ENA,
    input  logic [DWIDTH-1:0] DATA_IN,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              F_FULL,
    output logic              F_EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int unsigned   DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic wr_acc;
    logic rd_acc;

    // A full FIFO still takes a write when a read frees the head slot in the same edge.
    assign wr_acc = WR_ENA & (~full_q | RD_ENA);
    assign rd_acc = RD_ENA & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        // Flags are derived from the next count so they stay aligned with COUNT.
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        ovf_d   = WR_ENA & ~wr_acc;
        udf_d   = RD_ENA & ~rd_acc;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge PCLK) begin
        if (PRESETn && wr_acc) begin
            mem[wr_ptr_q] <= DATA_IN;
        end
    end

    assign DATA_OUT  = empty_q ? '0 : mem[rd_ptr_q];
    assign F_FULL    = full_q;
    assign F_EMPTY   = empty_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// tb_i2c_fifo: directed self-checking bench for i2c_fifo (DWIDTH 32, AWIDTH 5).
module tb_i2c_fifo;

    logic        PCLK;
    logic        PRESETn;
    logic        WR_ENA;
    logic        RD_ENA;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        F_FULL;
    logic        F_EMPTY;
    logic [5:0]  COUNT;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int n_tests;
    int n_fail;

    i2c_fifo #(
        .DWIDTH(32),
        .AWIDTH(5)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .WR_ENA   (WR_ENA),
        .RD_ENA   (RD_ENA),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .F_FULL   (F_FULL),
        .F_EMPTY  (F_EMPTY),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW),
        .UNDERFLOW(UNDERFLOW)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [5:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        udf;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [5:0] cnt, input logic full,
                               input logic empty, input logic ovf, input logic udf,
                               input logic [31:0] dout);
        check({tag, ".count"}, 32'(COUNT), 32'(cnt));
        check({tag, ".full"}, 32'(F_FULL), 32'(full));
        check({tag, ".empty"}, 32'(F_EMPTY), 32'(empty));
        check({tag, ".overflow"}, 32'(OVERFLOW), 32'(ovf));
        check({tag, ".underflow"}, 32'(UNDERFLOW), 32'(udf));
        check({tag, ".data_out"}, DATA_OUT, dout);
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Ordering, empty reads, and simultaneous access while empty.
        vecs[0]  = '{1'b1, 1'b0, 32'h11, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[1]  = '{1'b1, 1'b0, 32'h22, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[2]  = '{1'b1, 1'b0, 32'h33, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,  6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,  6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33};
        vecs[5]  = '{1'b0, 1'b1, 32'h0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h44, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44};
        vecs[10] = '{1'b0, 1'b1, 32'h0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        WR_ENA  = 1'b0;
        RD_ENA  = 1'b0;
        DATA_IN = '0;
        PRESETn = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        check_state("reset", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        PRESETn = 1'b1;
        step();
        check_state("idle", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 11; i++) begin
            WR_ENA  = vecs[i].wr;
            RD_ENA  = vecs[i].rd;
            DATA_IN = vecs[i].din;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                        vecs[i].ovf, vecs[i].udf, vecs[i].dout);
        end
        WR_ENA = 1'b0;
        RD_ENA = 1'b0;

        // Fill to full with 0..31.
        for (int i = 0; i < 32; i++) begin
            WR_ENA  = 1'b1;
            DATA_IN = 32'(i);
            step();
        end
        WR_ENA = 1'b0;
        check_state("filled", 6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Rejected write while full.
        WR_ENA  = 1'b1;
        DATA_IN = 32'hDEAD;
        step();
        WR_ENA = 1'b0;
        check_state("overflow", 6'd32, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_state("overflow_end", 6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Simultaneous read and write while full: word 0 leaves, 0xA5 joins at the tail.
        WR_ENA  = 1'b1;
        RD_ENA  = 1'b1;
        DATA_IN = 32'hA5;
        #1;
        check("full_rw.head", DATA_OUT, 32'h0);
        step();
        WR_ENA = 1'b0;
        RD_ENA = 1'b0;
        check_state("full_rw", 6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1);

        // Drain: 1..31 then 0xA5.
        for (int i = 0; i < 32; i++) begin
            RD_ENA = 1'b1;
            check($sformatf("drain%0d", i), DATA_OUT, (i < 31) ? 32'(i + 1) : 32'hA5);
            step();
        end
        RD_ENA = 1'b0;
        check_state("drained", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // 40 write/read pairs walk both pointers past the wrap point.
        for (int i = 0; i < 40; i++) begin
            WR_ENA  = 1'b1;
            DATA_IN = 32'h100 + 32'(i);
            step();
            WR_ENA = 1'b0;
            RD_ENA = 1'b1;
            check($sformatf("wrap%0d", i), DATA_OUT, 32'h100 + 32'(i));
            step();
            RD_ENA = 1'b0;
        end
        check_state("wrapped", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 5; i++) begin
            WR_ENA  = 1'b1;
            DATA_IN = 32'h200 + 32'(i);
            step();
        end
        WR_ENA = 1'b0;
        check_state("five", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200);

        // Mid-cycle reset must clear immediately and ignore requests while held.
        #2;
        PRESETn = 1'b0;
        WR_ENA  = 1'b1;
        DATA_IN = 32'h99;
        #1;
        check_state("async_reset", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        check_state("reset_held", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        PRESETn = 1'b1;
        DATA_IN = 32'h77;
        step();
        WR_ENA = 1'b0;
        check_state("after_reset", 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
